// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// Holds the RISC-V load/store funct3 encodings and the FSM state type.
package dmem_pkg;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Sh  = 3'b001;
  localparam logic [2:0] F3Sw  = 3'b010;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering for loads/stores: byte enables, store replication, load extend, errors.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses instead of aligning down.
module dmem_align
  import dmem_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_word_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wdata_lanes_o,
  output logic [31:0] load_data_o,
  output logic        err_o
);

  logic [1:0]  lo;
  logic        legal;
  logic [31:0] shifted;

  always_comb begin
    lo    = addr_lo_i;
    legal = 1'b0;
    case (funct3_i[1:0])
      2'b01:   lo = {addr_lo_i[1], 1'b0};
      2'b10:   lo = 2'b00;
      default: lo = addr_lo_i;
    endcase

    if (we_i) begin
      legal = (funct3_i == F3Sb) || (funct3_i == F3Sh) || (funct3_i == F3Sw);
    end else begin
      legal = (funct3_i == F3Lb) || (funct3_i == F3Lh) || (funct3_i == F3Lw) ||
              (funct3_i == F3Lbu) || (funct3_i == F3Lhu);
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    err_o = !legal || ((funct3_i[1:0] == 2'b01) && addr_lo_i[0]) ||
            ((funct3_i[1:0] == 2'b10) && (addr_lo_i != 2'b00));
`else
    err_o = !legal;
`endif

    shifted = rdata_word_i >> {lo, 3'b000};
    load_data_o = 32'h0;
    if (!we_i && !err_o) begin
      case (funct3_i)
        F3Lb:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
        F3Lh:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
        F3Lw:    load_data_o = shifted;
        F3Lbu:   load_data_o = {24'h0, shifted[7:0]};
        F3Lhu:   load_data_o = {16'h0, shifted[15:0]};
        default: load_data_o = 32'h0;
      endcase
    end

    // Replicate store data across all lanes; byte enables pick the live ones.
    byte_en_o = 4'b0000;
    case (funct3_i[1:0])
      2'b00: begin
        wdata_lanes_o = {4{wdata_i[7:0]}};
        byte_en_o     = 4'b0001 << lo;
      end
      2'b01: begin
        wdata_lanes_o = {2{wdata_i[15:0]}};
        byte_en_o     = 4'b0011 << lo;
      end
      default: begin
        wdata_lanes_o = wdata_i;
        byte_en_o     = 4'b1111;
      end
    endcase
    if (!we_i || err_o) byte_en_o = 4'b0000;
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed added latency and RISC-V sized accesses.
// Misaligned-access trapping is enabled by defining DMEM_MISALIGN_TRAP_EN (see dmem_align).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned Depth   = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  CntInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  we_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [2:0]            funct3_q;
  logic [31:0]           wdata_q;
  logic [31:0]           resp_rdata_q;
  logic                  resp_err_q;

  logic [31:0] mem [Depth];

  logic                  live;
  logic                  enter_resp;
  logic                  acc_we;
  logic [ADDR_WIDTH+1:0] acc_addr;
  logic [2:0]            acc_funct3;
  logic [31:0]           acc_wdata;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [3:0]            byte_en;
  logic [31:0]           wdata_lanes;
  logic [31:0]           load_data;
  logic                  align_err;
  logic                  unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

  // With zero wait the access happens on the accept edge, so use the live request fields.
  assign live       = (state_q == StIdle);
  assign acc_we     = live ? req_we : we_q;
  assign acc_addr   = live ? req_addr[ADDR_WIDTH+1:0] : addr_q;
  assign acc_funct3 = live ? req_funct3 : funct3_q;
  assign acc_wdata  = live ? req_wdata : wdata_q;
  assign word_idx   = acc_addr[ADDR_WIDTH+1:2];

  assign enter_resp = ((state_q == StWait) && (cnt_q == 4'd0)) ||
                      (live && req_valid && (WAIT_CYCLES == 0));

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  dmem_align u_align (
    .we_i         (acc_we),
    .funct3_i     (acc_funct3),
    .addr_lo_i    (acc_addr[1:0]),
    .wdata_i      (acc_wdata),
    .rdata_word_i (mem[word_idx]),
    .byte_en_o    (byte_en),
    .wdata_lanes_o(wdata_lanes),
    .load_data_o  (load_data),
    .err_o        (align_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      funct3_q     <= 3'b000;
      wdata_q      <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q     <= req_we;
            addr_q   <= req_addr[ADDR_WIDTH+1:0];
            funct3_q <= req_funct3;
            wdata_q  <= req_wdata;
            if (WAIT_CYCLES == 0) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= CntInit;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) state_q <= StResp;
          else cnt_q <= cnt_q - 4'd1;
        end
        StResp: begin
          if (resp_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      if (enter_resp) begin
        resp_rdata_q <= load_data;
        resp_err_q   <= align_err;
      end
    end
  end

  // Memory is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (enter_resp && byte_en[i]) mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
    end
  end

endmodule
